uart_frame_sampler: RTL and testbench
=====================================

UART_FRAME_SAMPLER -- requirements
Module: uart_frame_sampler

Interface
REQ-001 Parameter OVERSAMPLE, default 16, oversampling ticks per bit; legal values 8 and 16 only.
REQ-002 Parameter MAX_DATA_BITS, default 8, width of data_out; frame data length never exceeds it.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick_os  input  1  one-clk-wide oversampling tick, OVERSAMPLE per bit period.
REQ-006 rx_filtered  input  1  filtered serial line, idle high.
REQ-007 falling_edge  input  1  one-clk pulse marking a high-to-low transition on rx_filtered.
REQ-008 enable  input  1  receiver enable; low forces IDLE.
REQ-009 cfg_data_bits  input  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
REQ-010 cfg_parity_en  input  1  parity bit present after data.
REQ-011 cfg_parity_odd  input  1  1=odd parity, 0=even parity.
REQ-012 cfg_stop2  input  1  1=two stop bits, 0=one.
REQ-013 data_out  output  MAX_DATA_BITS  received data, LSB first on the line, right-justified, unused upper bits 0.
REQ-014 data_valid  output  1  one-clk pulse: data_out, parity_err, frame_err valid.
REQ-015 parity_err  output  1  parity mismatch; meaningful only with data_valid.
REQ-016 frame_err  output  1  a stop bit voted 0; meaningful only with data_valid.
REQ-017 start_detected  output  1  one-clk pulse on a confirmed start bit.
REQ-018 busy  output  1  high whenever state is not IDLE.

Function
REQ-019 States: IDLE, START, DATA, PARITY, STOP; tick counter cnt runs 0..OVERSAMPLE-1 and advances only on tick_os; bit index runs 0..N-1.
REQ-020 IDLE: on falling_edge with enable=1, latch all cfg_* inputs, clear cnt to 0, go to START the next clk; falling_edge outside IDLE is ignored.
REQ-021 Majority vote per bit: capture rx_filtered on tick_os at cnt = MID-1, MID, MID+1 (MID = OVERSAMPLE/2); the vote is the 2-of-3 majority, resolved at the cnt = MID+1 tick.
REQ-022 Bit boundary: a tick_os at cnt = OVERSAMPLE-1 wraps cnt to 0 and moves to the next bit/state.
REQ-023 START: a vote of 1 returns to IDLE the next clk with no output (false start); a vote of 0 pulses start_detected the next clk, then enters DATA at the bit boundary.
REQ-024 DATA: each vote is written to data bit position bit index; at the boundary of bit N-1, go to PARITY if parity is enabled, else STOP.
REQ-025 PARITY: expected bit = XOR of the N data bits, inverted when odd; a mismatch with the vote sets the internal parity flag; go to STOP at the boundary.
REQ-026 STOP: a vote of 0 on any stop bit sets the internal frame flag; with cfg_stop2 latched, the first stop bit proceeds to a second stop bit at its boundary.
REQ-027 On the vote of the last stop bit, the block returns to IDLE, and the next clk pulses data_valid with data_out, parity_err and frame_err; it does not wait for the stop-bit boundary.
REQ-028 data_out holds its value until the next data_valid; parity_err and frame_err are 0 outside the data_valid cycle.
REQ-029 Config changes mid-frame have no effect until the next start.
REQ-030 A clk with falling_edge in IDLE and the data_valid pulse in the same cycle is legal; the new frame starts normally.
REQ-031 enable=0 in any state forces IDLE on the next clk, discards the partial frame, and suppresses all pulses.

Reset
REQ-032 rst=1 at a clk edge sets IDLE, cnt=0, bit index 0, data_out=0, data_valid=0, parity_err=0, frame_err=0, start_detected=0, busy=0; this holds mid-frame with no pulse emitted.

Verification
REQ-033 OVERSAMPLE=16, 8N1, send 0xA5 -> one start_detected, then data_valid with data_out=0xA5, both error flags 0.
REQ-034 7E1, send 0x3C with correct parity, then 0x3C with parity bit flipped -> data_out=0x3C both times; parity_err 0 then 1.
REQ-035 8N2, send 0x81 with the second stop bit driven 0 -> data_valid with frame_err=1, data_out=0x81.
REQ-036 Low glitch of 4 ticks after falling_edge -> no start_detected, no data_valid, busy returns to 0.
REQ-037 Single-tick line inversion at cnt=MID on every data bit of 0x55 -> majority vote yields data_out=0x55.
REQ-038 OVERSAMPLE=8, 5N1, back-to-back frames 0x1F then 0x0A with no idle gap, and rst asserted mid-third frame -> two data_valid pulses with correct data, then all outputs 0 after rst.

Source files
------------

// File: rtl/uart_frame_sampler.sv
// UART receive framer: majority-votes each oversampled bit and assembles
// start/data/parity/stop into a data word with parity and framing flags.
module uart_frame_sampler #(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_os,
  input  logic                     rx_filtered,
  input  logic                     falling_edge,
  input  logic                     enable,
  input  logic [1:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop2,
  output logic [MAX_DATA_BITS-1:0] data_out,
  output logic                     data_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     start_detected,
  output logic                     busy,
  output logic [2:0]               state_dbg
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [3:0]               bit_idx_q, bit_idx_d;
  logic                     stop_idx_q, stop_idx_d;
  logic [1:0]               samp_q, samp_d;
  logic [MAX_DATA_BITS-1:0] shift_q, shift_d;
  logic                     pflag_q, pflag_d;
  logic                     fflag_q, fflag_d;
  logic [1:0]               data_bits_q, data_bits_d;
  logic                     parity_en_q, parity_en_d;
  logic                     parity_odd_q, parity_odd_d;
  logic                     stop2_q, stop2_d;
  logic [MAX_DATA_BITS-1:0] data_out_q, data_out_d;
  logic                     data_valid_q, data_valid_d;
  logic                     parity_err_q, parity_err_d;
  logic                     frame_err_q, frame_err_d;
  logic                     start_det_q, start_det_d;

  logic       vote;
  logic       at_vote;
  logic       at_end;
  logic [3:0] nbits_m1;

  // The third sample is taken live on the resolving tick, so only two are stored.
  assign vote     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_filtered) |
                    (samp_q[1] & rx_filtered);
  assign at_vote  = tick_os && (cnt_q == CW'(MID + 1));
  assign at_end   = tick_os && (cnt_q == CW'(OVERSAMPLE - 1));
  assign nbits_m1 = {2'b00, data_bits_q} + 4'd4;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    pflag_d      = pflag_q;
    fflag_d      = fflag_q;
    data_bits_d  = data_bits_q;
    parity_en_d  = parity_en_q;
    parity_odd_d = parity_odd_q;
    stop2_d      = stop2_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    start_det_d  = 1'b0;

    if (tick_os && (state_q != IDLE)) begin
      cnt_d = at_end ? '0 : cnt_q + 1'b1;
      if (cnt_q == CW'(MID - 1)) samp_d[0] = rx_filtered;
      if (cnt_q == CW'(MID))     samp_d[1] = rx_filtered;
    end

    case (state_q)
      IDLE: begin
        if (falling_edge && enable) begin
          data_bits_d  = cfg_data_bits;
          parity_en_d  = cfg_parity_en;
          parity_odd_d = cfg_parity_odd;
          stop2_d      = cfg_stop2;
          cnt_d        = '0;
          bit_idx_d    = '0;
          stop_idx_d   = 1'b0;
          shift_d      = '0;
          pflag_d      = 1'b0;
          fflag_d      = 1'b0;
          state_d      = START;
        end
      end
      START: begin
        if (at_vote) begin
          if (vote) state_d = IDLE;
          else      start_det_d = 1'b1;
        end
        if (at_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (at_vote) begin
          for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (bit_idx_q == 4'(i)) shift_d[i] = vote;
          end
        end
        if (at_end) begin
          if (bit_idx_q == nbits_m1) begin
            state_d    = parity_en_q ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (at_vote) pflag_d = vote ^ (^shift_q) ^ parity_odd_q;
        if (at_end) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end
      STOP: begin
        // The last stop bit completes the frame at its vote, not its boundary.
        if (at_vote) begin
          if (!stop2_q || stop_idx_q) begin
            state_d      = IDLE;
            data_valid_d = 1'b1;
            data_out_d   = shift_q;
            parity_err_d = pflag_q;
            frame_err_d  = fflag_q | ~vote;
          end else begin
            fflag_d = fflag_q | ~vote;
          end
        end
        if (at_end) stop_idx_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d      = IDLE;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      start_det_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      samp_q       <= '0;
      shift_q      <= '0;
      pflag_q      <= 1'b0;
      fflag_q      <= 1'b0;
      data_bits_q  <= '0;
      parity_en_q  <= 1'b0;
      parity_odd_q <= 1'b0;
      stop2_q      <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      start_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      pflag_q      <= pflag_d;
      fflag_q      <= fflag_d;
      data_bits_q  <= data_bits_d;
      parity_en_q  <= parity_en_d;
      parity_odd_q <= parity_odd_d;
      stop2_q      <= stop2_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      start_det_q  <= start_det_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_valid     = data_valid_q;
  assign parity_err     = parity_err_q;
  assign frame_err      = frame_err_q;
  assign start_detected = start_det_q;
  assign busy           = (state_q != IDLE);
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_uart_frame_sampler.sv
// Bench for uart_frame_sampler: an OVERSAMPLE=16 and an OVERSAMPLE=8 instance
// share the serial line; each is enabled only while its own frames are sent.
module tb_uart_frame_sampler;

  logic       clk = 1'b0;
  logic       rst16 = 1'b1, rst8 = 1'b1;
  logic       en16 = 1'b0, en8 = 1'b0;
  logic       tick = 1'b0, rx = 1'b1, fe = 1'b0;
  logic [1:0] cfg_bits = 2'd3;
  logic       cfg_pen = 1'b0, cfg_odd = 1'b0, cfg_stop2 = 1'b0;

  logic [7:0] do16, do8;
  logic       dv16, dv8, pe16, pe8, fr16, fr8, sd16, sd8, busy16, busy8;
  logic [2:0] dbg16, dbg8;

  int checks = 0;
  int errors = 0;
  int starts16 = 0, starts8 = 0;
  // {parity_err, frame_err, data_out}
  logic [9:0] exp16_q[$];
  logic [9:0] exp8_q[$];

  always #5 clk = ~clk;

  uart_frame_sampler #(.OVERSAMPLE(16), .MAX_DATA_BITS(8)) dut16 (
    .clk(clk), .rst(rst16), .tick_os(tick), .rx_filtered(rx), .falling_edge(fe),
    .enable(en16), .cfg_data_bits(cfg_bits), .cfg_parity_en(cfg_pen),
    .cfg_parity_odd(cfg_odd), .cfg_stop2(cfg_stop2), .data_out(do16),
    .data_valid(dv16), .parity_err(pe16), .frame_err(fr16),
    .start_detected(sd16), .busy(busy16), .state_dbg(dbg16)
  );

  uart_frame_sampler #(.OVERSAMPLE(8), .MAX_DATA_BITS(8)) dut8 (
    .clk(clk), .rst(rst8), .tick_os(tick), .rx_filtered(rx), .falling_edge(fe),
    .enable(en8), .cfg_data_bits(cfg_bits), .cfg_parity_en(cfg_pen),
    .cfg_parity_odd(cfg_odd), .cfg_stop2(cfg_stop2), .data_out(do8),
    .data_valid(dv8), .parity_err(pe8), .frame_err(fr8),
    .start_detected(sd8), .busy(busy8), .state_dbg(dbg8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Each oversampling tick is one clk high then one clk low.
  task automatic drive_tick(input logic val);
    @(negedge clk);
    fe   = rx & ~val;
    rx   = val;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    fe   = 1'b0;
  endtask

  task automatic drive_bit(input int os, input logic val, input int glitch_off);
    for (int k = 0; k < os; k++) drive_tick((k == glitch_off) ? ~val : val);
  endtask

  task automatic send_frame(input int os, input logic [7:0] data, input int nbits,
                            input logic flip_par, input logic last_stop, input int glitch_off);
    logic p;
    drive_bit(os, 1'b0, -1);
    for (int i = 0; i < nbits; i++) drive_bit(os, data[i], glitch_off);
    if (cfg_pen) begin
      p = cfg_odd;
      for (int i = 0; i < nbits; i++) p = p ^ data[i];
      drive_bit(os, p ^ flip_par, -1);
    end
    if (cfg_stop2) drive_bit(os, 1'b1, -1);
    drive_bit(os, last_stop, -1);
  endtask

  task automatic set_cfg(input logic [1:0] bits, input logic pen, input logic odd, input logic s2);
    cfg_bits = bits; cfg_pen = pen; cfg_odd = odd; cfg_stop2 = s2;
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (sd16) starts16++;
    if (sd8)  starts8++;
    if (dv16) begin
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("FAIL dut16_unexpected_valid actual=%0h expected=none", {pe16, fr16, do16});
      end else begin
        e = exp16_q.pop_front();
        if ({pe16, fr16, do16} !== e) begin
          errors++;
          $display("FAIL dut16_frame actual=%0h expected=%0h", {pe16, fr16, do16}, e);
        end
      end
    end
    if (dv8) begin
      checks++;
      if (exp8_q.size() == 0) begin
        errors++;
        $display("FAIL dut8_unexpected_valid actual=%0h expected=none", {pe8, fr8, do8});
      end else begin
        e = exp8_q.pop_front();
        if ({pe8, fr8, do8} !== e) begin
          errors++;
          $display("FAIL dut8_frame actual=%0h expected=%0h", {pe8, fr8, do8}, e);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst16 = 1'b0; rst8 = 1'b0; en16 = 1'b1;
    @(negedge clk);
    check("rst_data_out", {24'd0, do16}, 32'h0);
    check("rst_flags", {28'd0, dv16, pe16, fr16, sd16}, 32'h0);
    check("rst_busy", {31'd0, busy16}, 32'h0);
    check("rst_state", {29'd0, dbg16}, 32'h0);

    // 8N1 0xA5
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    exp16_q.push_back({2'b00, 8'hA5});
    send_frame(16, 8'hA5, 8, 1'b0, 1'b1, -1);
    drive_bit(16, 1'b1, -1);

    // 7E1 0x3C good parity, then flipped parity
    set_cfg(2'd2, 1'b1, 1'b0, 1'b0);
    exp16_q.push_back({2'b00, 8'h3C});
    send_frame(16, 8'h3C, 7, 1'b0, 1'b1, -1);
    exp16_q.push_back({2'b10, 8'h3C});
    send_frame(16, 8'h3C, 7, 1'b1, 1'b1, -1);
    drive_bit(16, 1'b1, -1);

    // 8N2 0x81, second stop bit low
    set_cfg(2'd3, 1'b0, 1'b0, 1'b1);
    exp16_q.push_back({2'b01, 8'h81});
    send_frame(16, 8'h81, 8, 1'b0, 1'b0, -1);
    drive_bit(16, 1'b1, -1);

    // 4-tick low glitch: false start
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive_tick(1'b0);
    drive_bit(16, 1'b1, -1);
    check("glitch_busy", {31'd0, busy16}, 32'h0);
    check("glitch_starts", starts16, 32'd4);

    // 0x55 with one inverted tick at cnt=MID on every data bit
    exp16_q.push_back({2'b00, 8'h55});
    send_frame(16, 8'h55, 8, 1'b0, 1'b1, 9);
    drive_bit(16, 1'b1, -1);
    check("hold_data_out", {24'd0, do16}, 32'h55);

    // Drop enable mid-frame: partial frame discarded
    drive_bit(16, 1'b0, -1);
    drive_bit(16, 1'b1, -1);
    drive_bit(16, 1'b0, -1);
    en16 = 1'b0;
    @(negedge clk);
    check("enable_drop_busy", {31'd0, busy16}, 32'h0);
    rx = 1'b1;
    drive_bit(16, 1'b1, -1);
    en16 = 1'b1;
    drive_bit(16, 1'b1, -1);
    check("dut16_queue_empty", exp16_q.size(), 32'd0);
    check("dut16_starts", starts16, 32'd6);
    en16 = 1'b0;

    // OVERSAMPLE=8, 5N1, back-to-back frames then reset mid third frame
    en8 = 1'b1;
    set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
    drive_bit(8, 1'b1, -1);
    exp8_q.push_back({2'b00, 8'h1F});
    send_frame(8, 8'h1F, 5, 1'b0, 1'b1, -1);
    exp8_q.push_back({2'b00, 8'h0A});
    send_frame(8, 8'h0A, 5, 1'b0, 1'b1, -1);
    check("dut8_hold_data_out", {24'd0, do8}, 32'h0A);
    drive_bit(8, 1'b0, -1);
    drive_bit(8, 1'b1, -1);
    drive_bit(8, 1'b0, -1);
    check("dut8_busy_mid", {31'd0, busy8}, 32'h1);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    check("dut8_rst_data_out", {24'd0, do8}, 32'h0);
    check("dut8_rst_flags", {28'd0, dv8, pe8, fr8, sd8}, 32'h0);
    check("dut8_rst_busy", {31'd0, busy8}, 32'h0);
    check("dut8_rst_state", {29'd0, dbg8}, 32'h0);
    rx = 1'b1;
    drive_bit(8, 1'b1, -1);
    drive_bit(8, 1'b1, -1);
    check("dut8_post_rst_data_out", {24'd0, do8}, 32'h0);
    check("dut8_queue_empty", exp8_q.size(), 32'd0);
    check("dut8_starts", starts8, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
